// File: rtl/jstk_pkg.sv
// Shared types and constants for the PMOD JSTK poll controller.
package jstk_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StXfer,
        StDecode,
        StGap
    } state_e;

    localparam logic [7:0] JSTK_CMD_LED = 8'h80;

    // Bit offsets of the reply fields inside the 40-bit inbound word
    localparam int unsigned X_LO = 32;
    localparam int unsigned X_HI = 24;
    localparam int unsigned Y_LO = 16;
    localparam int unsigned Y_HI = 8;
    localparam int unsigned BTN  = 0;

    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer; resets to 1 so an active-low strobe idles deasserted.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/jstk_poll_ctrl.sv
// Periodic poll sequencer for the PMOD JSTK: triggers the SPI master, tracks the
// transfer through cs, and decodes the 5-byte reply into position and buttons.
import jstk_pkg::*;

module jstk_poll_ctrl #(
    parameter int unsigned POLL_GAP     = 20000,
    parameter int unsigned TRIG_TIMEOUT = 1024,
    parameter int unsigned XFER_TIMEOUT = 32768
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  leds,
    output logic        spi_trigger,
    output logic [39:0] spi_out_bytes,
    input  logic [39:0] spi_in_bytes,
    input  logic        spi_cs,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [2:0]  btn,
    output logic        sample_valid,
    output logic        busy,
    output logic        trig_err,
    output logic        xfer_err
);

    localparam logic [CNT_W-1:0] GapLast  = CNT_W'(POLL_GAP - 1);
    localparam logic [CNT_W-1:0] TrigLast = CNT_W'(TRIG_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] XferLast = CNT_W'(XFER_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [7:0]         cmd_q, cmd_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic [2:0]         btn_q, btn_d;
    logic               trig_err_q, trig_err_d;
    logic               xfer_err_q, xfer_err_d;
    logic               cs_prev_q, cs_prev_d;
    logic               armed_q, armed_d;
    logic               cs_s;
    logic [9:0]         x_dec, y_dec;
    logic [2:0]         btn_dec;
    logic               unused_in;

    sync_2ff u_cs_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (spi_cs),
        .q_o     (cs_s)
    );

    assign x_dec     = {spi_in_bytes[X_HI +: 2], spi_in_bytes[X_LO +: 8]};
    assign y_dec     = {spi_in_bytes[Y_HI +: 2], spi_in_bytes[Y_LO +: 8]};
    assign btn_dec   = spi_in_bytes[BTN +: 3];
    assign unused_in = ^{spi_in_bytes[31:26], spi_in_bytes[15:10], spi_in_bytes[7:3]};

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        cmd_d      = cmd_q;
        x_d        = x_q;
        y_d        = y_q;
        btn_d      = btn_q;
        trig_err_d = trig_err_q;
        xfer_err_d = xfer_err_q;
        cs_prev_d  = cs_s;
        armed_d    = armed_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (enable) state_d = StTrig;
            end
            StTrig: begin
                // cs must be seen idle once the synchronizer has flushed, so a
                // transfer still running across a reset is not mistaken for ours.
                if (cs_s && cnt_q != '0) armed_d = 1'b1;
                if (armed_q && !cs_s) begin
                    state_d = StXfer;
                    cnt_d   = '0;
                end else if (cnt_q == TrigLast) begin
                    state_d    = StGap;
                    cnt_d      = '0;
                    trig_err_d = 1'b1;
                end
            end
            StXfer: begin
                if (cs_s && !cs_prev_q) begin
                    state_d = StDecode;
                    cnt_d   = '0;
                end else if (cnt_q == XferLast) begin
                    state_d    = StGap;
                    cnt_d      = '0;
                    xfer_err_d = 1'b1;
                end
            end
            StDecode: begin
                x_d     = x_dec;
                y_d     = y_dec;
                btn_d   = btn_dec;
                state_d = StGap;
                cnt_d   = '0;
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    state_d = enable ? StTrig : StIdle;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Command and arming are refreshed on every entry into TRIG
        if (state_d == StTrig && state_q != StTrig) begin
            cmd_d   = JSTK_CMD_LED | {6'b0, leds};
            armed_d = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            cmd_q      <= 8'h00;
            x_q        <= '0;
            y_q        <= '0;
            btn_q      <= '0;
            trig_err_q <= 1'b0;
            xfer_err_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            x_q        <= x_d;
            y_q        <= y_d;
            btn_q      <= btn_d;
            trig_err_q <= trig_err_d;
            xfer_err_q <= xfer_err_d;
            cs_prev_q  <= cs_prev_d;
            armed_q    <= armed_d;
        end
    end

    assign spi_trigger   = (state_q == StTrig);
    assign spi_out_bytes = {cmd_q, 32'h0};
    assign sample_valid  = (state_q == StDecode);
    assign busy          = (state_q != StIdle);
    // Fresh decode is visible in the same cycle as the sample_valid pulse
    assign x_pos         = sample_valid ? x_dec : x_q;
    assign y_pos         = sample_valid ? y_dec : y_q;
    assign btn           = sample_valid ? btn_dec : btn_q;
    assign trig_err      = trig_err_q;
    assign xfer_err      = xfer_err_q;

endmodule

// File: tb/tb_jstk_poll_ctrl.sv
// Bench for jstk_poll_ctrl: behavioural SPI model, sample scoreboard, vector table.
module tb_jstk_poll_ctrl;

    localparam int unsigned P      = 500;
    localparam int unsigned T      = 2048;
    localparam int unsigned XT     = 4096;
    localparam int unsigned CS_LAT = 300;
    localparam int unsigned CS_LOW = 1000;
    localparam int unsigned XFER_BUDGET = P + CS_LAT + CS_LOW + 200;

    typedef struct {
        logic [1:0]  leds;
        logic [39:0] resp;
        logic [39:0] out;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
    } vec_t;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] btn;
    } samp_t;

    typedef enum int {MNormal, MDead, MStuck} mode_e;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  leds;
    logic        spi_trigger;
    logic [39:0] spi_out_bytes;
    logic [39:0] spi_in_bytes;
    logic        spi_cs;
    logic [9:0]  x_pos, y_pos;
    logic [2:0]  btn;
    logic        sample_valid, busy, trig_err, xfer_err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          trig_rises = 0, sv_cnt = 0;
    int          trig_rise_cyc = 0, trig_fall_cyc = 0, sv_cyc = 0, cs_fall_cyc = 0;
    logic        trig_prev = 1'b0;
    mode_e       mode = MNormal;
    logic [39:0] cur_resp;
    samp_t       cur_exp;
    samp_t       exp_q[$];
    vec_t        vec[4];

    jstk_poll_ctrl #(
        .POLL_GAP     (P),
        .TRIG_TIMEOUT (T),
        .XFER_TIMEOUT (XT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .leds          (leds),
        .spi_trigger   (spi_trigger),
        .spi_out_bytes (spi_out_bytes),
        .spi_in_bytes  (spi_in_bytes),
        .spi_cs        (spi_cs),
        .x_pos         (x_pos),
        .y_pos         (y_pos),
        .btn           (btn),
        .sample_valid  (sample_valid),
        .busy          (busy),
        .trig_err      (trig_err),
        .xfer_err      (xfer_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind 0: new trigger rise, 1: new sample, 2: trigger low, 3: xfer_err high
    task automatic wait_ev(input string name, input int kind, input int budget);
        int r0 = trig_rises;
        int s0 = sv_cnt;
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk); #1;
            case (kind)
                0: hit = (trig_rises != r0);
                1: hit = (sv_cnt != s0);
                2: hit = !spi_trigger;
                3: hit = xfer_err;
                default: hit = 1'b1;
            endcase
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    task automatic load_vec(input int i);
        leds        = vec[i].leds;
        cur_resp    = vec[i].resp;
        cur_exp.x   = vec[i].x;
        cur_exp.y   = vec[i].y;
        cur_exp.btn = vec[i].btn;
    endtask

    // Behavioural SPI master: honours trigger only while idle
    initial begin
        spi_cs       = 1'b1;
        spi_in_bytes = 40'h0;
        forever begin
            @(negedge clk);
            if (spi_trigger && mode != MDead) begin
                repeat (CS_LAT) @(negedge clk);
                spi_cs      = 1'b0;
                cs_fall_cyc = cyc;
                if (mode == MStuck) begin
                    while (mode == MStuck) @(negedge clk);
                end else begin
                    spi_in_bytes = cur_resp;
                    exp_q.push_back(cur_exp);
                    repeat (CS_LOW) @(negedge clk);
                end
                spi_cs = 1'b1;
            end
        end
    end

    // Monitor and scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            trig_prev = 1'b0;
        end else begin
            if (spi_trigger && !trig_prev) begin
                trig_rises++;
                trig_rise_cyc = cyc;
            end
            if (!spi_trigger && trig_prev) trig_fall_cyc = cyc;
            trig_prev = spi_trigger;
            if (sample_valid) begin
                sv_cnt++;
                sv_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample: got x=%0h y=%0h btn=%0h required none",
                             x_pos, y_pos, btn);
                end else begin
                    samp_t e;
                    e = exp_q.pop_front();
                    check("sample_xyb", {x_pos, y_pos, btn}, {e.x, e.y, e.btn});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, f, s0, rel_cyc;

        vec[0] = '{2'b10, 40'hA5_03_3C_01_05, 40'h82_0000_0000, 10'h3A5, 10'h13C, 3'b101};
        vec[1] = '{2'b00, 40'h00_00_00_00_00, 40'h80_0000_0000, 10'h000, 10'h000, 3'b000};
        vec[2] = '{2'b11, 40'hFF_FF_FF_FF_FF, 40'h83_0000_0000, 10'h3FF, 10'h3FF, 3'b111};
        vec[3] = '{2'b01, 40'h12_FE_34_FD_F8, 40'h81_0000_0000, 10'h212, 10'h134, 3'b000};

        reset_n = 1'b0;
        enable  = 1'b1;
        load_vec(0);
        repeat (4) @(negedge clk);
        #1;
        check("reset_outputs",
              {spi_trigger, spi_out_bytes, x_pos, y_pos, btn, sample_valid, busy, trig_err,
               xfer_err}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        rel_cyc = cyc;

        // Normal polling over the vector table
        for (int i = 0; i < 4; i++) begin
            if (i > 0) load_vec(i);
            wait_ev("trig_rise", 0, XFER_BUDGET);
            if (i == 0) check("first_trig_latency", 80'(trig_rise_cyc - rel_cyc), 80'd1);
            else        check("poll_gap_len", 80'(trig_rise_cyc - sv_cyc), 80'(P + 1));
            check("out_bytes", spi_out_bytes, vec[i].out);
            wait_ev("trig_drop", 2, CS_LAT + 20);
            check("trig_drop_le3", 80'(trig_fall_cyc - cs_fall_cyc <= 3 &&
                                       trig_fall_cyc - cs_fall_cyc >= 1), 80'd1);
            wait_ev("sample", 1, XFER_BUDGET);
        end

        // Trigger timeout: model ignores trigger
        mode = MDead;
        load_vec(0);
        wait_ev("t3_rise", 0, XFER_BUDGET);
        r = trig_rise_cyc;
        wait_ev("t3_fall", 2, T + 20);
        check("trig_hold_len", 80'(trig_fall_cyc - r), 80'(T));
        check("trig_err_set", trig_err, 1);
        s0 = sv_cnt;
        wait_ev("t3_retry", 0, P + 20);
        check("retry_gap_len", 80'(trig_rise_cyc - trig_fall_cyc), 80'(P));
        check("no_sample_on_trig_timeout", 80'(sv_cnt - s0), 80'd0);
        mode = MNormal;
        wait_ev("t3_sample", 1, XFER_BUDGET);

        // Transfer timeout: cs stuck low
        mode = MStuck;
        load_vec(1);
        wait_ev("t4_rise", 0, XFER_BUDGET);
        wait_ev("t4_fall", 2, CS_LAT + 20);
        f = trig_fall_cyc;
        wait_ev("t4_xfer_err", 3, XT + 20);
        check("xfer_timeout_len", 80'(cyc - f), 80'(XT));
        check("busy_after_xfer_err", busy, 1);
        check("xyb_unchanged", {x_pos, y_pos, btn}, {vec[0].x, vec[0].y, vec[0].btn});
        mode = MNormal;
        s0 = sv_cnt;
        repeat (20) @(negedge clk);
        #1;
        check("late_cs_rise_ignored", 80'(sv_cnt - s0), 80'd0);
        wait_ev("t4_sample", 1, XFER_BUDGET);

        // enable drops mid-transfer
        load_vec(2);
        wait_ev("t5_rise", 0, XFER_BUDGET);
        check("out_bytes_t5", spi_out_bytes, vec[2].out);
        wait_ev("t5_fall", 2, CS_LAT + 20);
        enable = 1'b0;
        wait_ev("t5_sample", 1, XFER_BUDGET);
        r = trig_rises;
        repeat (P + 20) @(negedge clk);
        #1;
        check("idle_after_disable", busy, 0);
        check("no_trig_while_disabled", 80'(trig_rises - r), 80'd0);
        load_vec(3);
        enable = 1'b1;
        @(negedge clk);
        #1;
        check("retrigger_on_enable", spi_trigger, 1);
        check("out_bytes_t5b", spi_out_bytes, vec[3].out);
        wait_ev("t5b_sample", 1, XFER_BUDGET);

        // Async reset in the middle of a transfer
        load_vec(0);
        wait_ev("t6_rise", 0, XFER_BUDGET);
        wait_ev("t6_fall", 2, CS_LAT + 20);
        repeat (200) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {spi_trigger, spi_out_bytes, x_pos, y_pos, btn, sample_valid, busy, trig_err,
               xfer_err}, '0);
        exp_q.delete();
        load_vec(3);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        s0 = sv_cnt;
        wait_ev("t6_trig", 0, 5);
        check("out_bytes_after_reset", spi_out_bytes, vec[3].out);
        wait_ev("t6_sample", 1, T + XFER_BUDGET);
        check("one_sample_after_reset", 80'(sv_cnt - s0), 80'd1);
        check("scoreboard_drained", 80'(exp_q.size()), 80'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
